// File: rtl/rr_arb4_ctl_if.sv
`default_nettype none
// ============================================================================
// Module : rr_arb4_ctl_if
// Desc   : requester-side / arbiter-side signal bundle for rr_arb4_ctl
// Rev    : 1.0
// ============================================================================
interface rr_arb4_ctl_if;
  logic [3:0] req_i;
  logic       done_i;
  logic [3:0] gnt_o;
  logic [1:0] owner_o;
  logic       busy_o;
  logic       anyreq_o;
  logic       tout_o;

  modport master (
    output req_i, done_i,
    input  gnt_o, owner_o, busy_o, anyreq_o, tout_o
  );

  modport slave (
    input  req_i, done_i,
    output gnt_o, owner_o, busy_o, anyreq_o, tout_o
  );
endinterface
`default_nettype wire

// File: rtl/rr_arb4_ctl.sv
`default_nettype none
// ============================================================================
// Module : rr_arb4_ctl
// Desc   : 4-way round-robin arbiter with one-cycle turnaround gap between
//          owners; RR_ARB4_HOLD_TIMEOUT_EN adds a MAXHOLD forced release.
// Rev    : 1.0
// ============================================================================
module rr_arb4_ctl #(
  parameter int unsigned PTR_INIT = 3,
  parameter int unsigned MAXHOLD  = 16
) (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  rr_arb4_ctl_if.slave bus
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_GRANT    = 2'd1;
  localparam logic [1:0] c_GAP      = 2'd2;
  localparam logic [1:0] c_PTR_INIT = 2'(PTR_INIT);

  if (MAXHOLD < 2 || MAXHOLD > 255) begin : g_maxhold_range
    $error("rr_arb4_ctl: MAXHOLD must be in 2..255");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q,  last_d;
  logic       busy_q,  busy_d;
  logic       tout_q,  tout_d;

  logic [7:0] w_req2;
  logic [3:0] w_rot;
  logic       w_win_vld;
  logic [1:0] w_win_off;
  logic [1:0] w_win_idx;
  logic       w_release;
  logic       w_timeout;

  // Rotate requests so bit 0 is the requester just after LAST.
  assign w_req2 = {bus.req_i, bus.req_i};
  assign w_rot  = w_req2[{1'b0, last_q} + 3'd1 +: 4];

  always_comb begin
    w_win_vld = 1'b1;
    w_win_off = 2'd0;
    if (w_rot[0])      w_win_off = 2'd0;
    else if (w_rot[1]) w_win_off = 2'd1;
    else if (w_rot[2]) w_win_off = 2'd2;
    else if (w_rot[3]) w_win_off = 2'd3;
    else               w_win_vld = 1'b0;
  end

  assign w_win_idx = last_q + 2'd1 + w_win_off;
  assign w_release = bus.done_i | ~bus.req_i[owner_q];

`ifdef RR_ARB4_HOLD_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign w_timeout = (state_q == c_GRANT) && (hold_q == 8'(MAXHOLD - 1));
  assign hold_d    = (state_q == c_GRANT && state_d == c_GRANT) ? hold_q + 8'd1 : 8'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) hold_q <= 8'd0;
    else       hold_q <= hold_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= c_IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      last_q  <= c_PTR_INIT;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_GRANT: if (w_release || w_timeout) state_d = c_GAP;
      default: state_d = w_win_vld ? c_GRANT : c_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = 4'b0000;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_d)
      c_GRANT: begin
        if (state_q != c_GRANT) begin
          owner_d = w_win_idx;
          last_d  = w_win_idx;
        end
        gnt_d  = 4'b0001 << owner_d;
        busy_d = 1'b1;
      end
      c_GAP:   tout_d = w_timeout & ~w_release;
      default: ;
    endcase
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.owner_o  = owner_q;
  assign bus.busy_o   = busy_q;
  assign bus.tout_o   = tout_q;
  assign bus.anyreq_o = |bus.req_i;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4_ctl.sv
`default_nettype none
// ============================================================================
// Module : tb_rr_arb4_ctl
// Desc   : directed + random stimulus checked against a cycle reference model
// Rev    : 1.0
// ============================================================================
module tb_rr_arb4_ctl;

  localparam int MAXHOLD  = 4;
  localparam int PTR_INIT = 3;
`ifdef RR_ARB4_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  rr_arb4_ctl_if u_if ();

  rr_arb4_ctl #(.PTR_INIT(PTR_INIT), .MAXHOLD(MAXHOLD)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the resource and for how many cycles so far.
  bit m_busy;
  int m_owner;
  int m_last;
  bit m_tout;
  int m_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input logic [3:0] q, input bit d);
    bit rel, to;
    if (r) begin
      m_busy = 0; m_owner = 0; m_last = PTR_INIT % 4; m_tout = 0; m_held = 0;
    end else if (m_busy) begin
      m_tout = 0;
      m_held++;
      rel = d || !q[m_owner];
      to  = TO_EN && (m_held >= MAXHOLD);
      if (rel || to) begin
        m_busy = 0;
        m_tout = to && !rel;
      end
    end else begin
      m_tout = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!m_busy && q[(m_last + k) % 4]) begin
          m_busy  = 1;
          m_owner = (m_last + k) % 4;
          m_last  = m_owner;
          m_held  = 0;
        end
      end
    end
  endtask

  // Drive at negedge, check ANYREQ, then check registered outputs after the edge.
  task automatic step(input bit r, input logic [3:0] q, input bit d);
    rst = r;
    u_if.req_i  = q;
    u_if.done_i = d;
    #1;
    check("anyreq", {31'd0, u_if.anyreq_o}, {31'd0, |q});
    @(posedge clk);
    model_edge(r, q, d);
    #1;
    check("gnt",   {28'd0, u_if.gnt_o},   m_busy ? (32'd1 << m_owner) : 32'd0);
    check("owner", {30'd0, u_if.owner_o}, 32'(m_owner));
    check("busy",  {31'd0, u_if.busy_o},  {31'd0, m_busy});
    check("tout",  {31'd0, u_if.tout_o},  {31'd0, m_tout});
    @(negedge clk);
  endtask

  logic [3:0] prev_gnt;
  logic [3:0] seen[$];
  logic [3:0] exp_seq [5];
  logic [3:0] rq;

  initial begin
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    u_if.req_i  = 4'b0000;
    u_if.done_i = 1'b0;
    @(negedge clk);

    // Idle after reset.
    step(1, 4'b0000, 0);
    step(1, 4'b0000, 0);
    for (int i = 0; i < 5; i++) step(0, 4'b0000, 0);

    // Full rotation with DONE on the 3rd grant cycle.
    prev_gnt = 4'b0000;
    for (int i = 0; i < 22; i++) begin
      step(0, 4'b1111, m_busy && m_held == 2);
      if (u_if.gnt_o != 4'b0000 && prev_gnt == 4'b0000) seen.push_back(u_if.gnt_o);
      prev_gnt = u_if.gnt_o;
    end
    check("seq_len", 32'(seen.size()) >= 32'd5 ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 5; i++)
      check("seq", (i < seen.size()) ? {28'd0, seen[i]} : 32'hFFFF, {28'd0, exp_seq[i]});

    // Single requester 2, then request drop.
    step(1, 4'b0000, 0);
    step(0, 4'b0100, 0);
    check("lat_gnt2", {28'd0, u_if.gnt_o}, 32'h4);
    for (int i = 0; i < 3; i++) step(0, 4'b0100, 0);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 0);

    // Owner 1 releases with 1011 pending: requester 3 next; DONE in GAP ignored.
    step(1, 4'b0000, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b1011, 1);
    step(0, 4'b1011, 1);
    check("rr_to3", {28'd0, u_if.gnt_o}, 32'h8);
    step(0, 4'b1011, 1);

    // Reset in the 2nd grant cycle, then re-grant.
    step(1, 4'b0000, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0010, 0);
    step(1, 4'b0010, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0010, 0);

    // Held grant: bounded by MAXHOLD only with the timeout feature.
    step(1, 4'b0000, 0);
    for (int i = 0; i < 12; i++) step(0, 4'b0011, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      rq = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rq = 4'b0000;
      step($urandom_range(0, 63) == 0, rq, $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rr_arb4_ctl.md
Name: rr_arb4_ctl

Overview:
- Four-requester round-robin arbiter/sequencer for one shared resource. Example resource: the common drive net of a 4-input OR cell fed by four agents.
- Issues one-hot registered grants and holds each grant until the owner signals DONE or drops its request.
- Inserts a one-cycle turnaround gap between owners.
- Sits between four requesting agents and the shared resource's enable logic.

Parameters:
- PTR_INIT, 3: reset value of the last-granted pointer. The default gives REQ[0] first priority after reset.
- MAXHOLD, 16: maximum consecutive grant cycles before forced release. Range 2..255. Used only with the optional feature.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset. Sampled on the CLK rising edge.
- REQ  input  4  per-requester request; bit i = requester i. Level-sensitive.
- DONE  input  1  owner's release pulse. Sampled only in GRANT.
- GNT  output  4  registered one-hot grant, or all zero.
- OWNER  output  2  registered index of the current or most recent owner.
- BUSY  output  1  registered; equals OR of GNT.
- ANYREQ  output  1  combinational OR of REQ[3:0].
- TOUT  output  1  registered one-cycle forced-release pulse. Tied 0 without the optional feature.

Behaviour:
- Clock and reset: single clock CLK. Reset RST is synchronous and active-high.
- Reset values: GNT=0000, OWNER=00, BUSY=0, TOUT=0, state=IDLE, LAST=PTR_INIT[1:0], hold counter=0.
- RST asserted during a grant: GNT drops at the edge where RST is sampled. DONE and REQ are ignored while RST=1.
- States:
  - IDLE: no grant held.
  - GRANT: one owner holds GNT.
  - GAP: one-cycle turnaround with GNT=0.
- Arbitration is performed in IDLE and GAP.
  - Search order is LAST+1, LAST+2, LAST+3, LAST (mod 4). The first set REQ bit wins.
  - If any bit is set, at the next edge: state=GRANT, GNT=onehot(winner), OWNER=winner, LAST=winner, BUSY=1.
  - If no bit is set: state=IDLE and GNT=0.
- Latency: REQ sampled high in IDLE at edge t gives GNT high after edge t (visible in cycle t+1).
- GRANT exit: leave at the next edge when DONE=1 or REQ[OWNER]=0.
  - Next state is GAP with GNT=0 and BUSY=0. OWNER and LAST are retained.
  - Other REQ bits have no effect while in GRANT. There is no preemption.
- GAP always lasts exactly one cycle, then arbitrates as above. Minimum owner-to-owner spacing is one dead cycle.
- Simultaneous events:
  - DONE and REQ[OWNER] falling together cause a single release.
  - DONE in IDLE or GAP is ignored.
- ANYREQ is purely combinational and has no reset dependency.
- GNT never has more than one bit set, in any cycle including the cycles around reset.

Optional Feature:
- Macro: RR_ARB4_HOLD_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAXHOLD-1 with no release condition, the next edge forces GRANT->GAP and sets TOUT=1 for exactly that GAP cycle.
  - If DONE or a REQ drop coincides with the timeout, it is a normal release and TOUT stays 0.
  - Net effect: a grant lasts at most MAXHOLD cycles.
- Undefined: no counter is present, TOUT is constant 0, and grants are unbounded.

Test Plan:
- Reset, then REQ=0000 for 5 cycles -> GNT=0000, BUSY=0, OWNER=00, ANYREQ=0, TOUT=0 throughout.
- After reset, REQ=1111 held, DONE pulsed on the 3rd grant cycle of each owner -> grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one GNT=0000 cycle between owners.
- REQ=0100 in IDLE at edge t -> GNT=0100 and OWNER=10 from cycle t+1. Dropping REQ[2] at edge t+4 -> GNT=0000 at t+5 (GAP), then IDLE.
- Owner 1 granted with REQ=1011 and DONE pulsed -> next grant goes to requester 3 (1000), not 0. Same DONE pulse while in GAP -> no effect.
- RST=1 asserted in the 2nd cycle of GNT=0010 -> GNT=0000, OWNER=00 at that edge. Released with REQ=0010 -> requester 1 is granted one cycle after the first non-reset edge.
- With RR_ARB4_HOLD_TIMEOUT_EN and MAXHOLD=4, REQ=0011 held with no DONE:
  - GNT=0001 for exactly 4 cycles.
  - Then GNT=0000 with TOUT=1 for one cycle.
  - Then GNT=0010.
  - Without the macro, GNT=0001 is held indefinitely and TOUT=0.
